// File: rtl/activate_if.sv
// activate_if: forward (arg/res) and backward (err/fbk) valid/ready channels of the activate stage
interface activate_if #(parameter int RESW = 16);
  logic            arg_valid;
  logic            arg_ready;
  logic [RESW-1:0] arg_data;
  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] res_data;
  logic            err_valid;
  logic            err_ready;
  logic [RESW-1:0] err_data;
  logic            fbk_valid;
  logic            fbk_ready;
  logic [RESW-1:0] fbk_data;
  modport master (
    output arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
    input  arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
  );
  modport slave (
    input  arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
    output arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
  );
endinterface

// File: rtl/activate.sv
// activate: piecewise-linear sigmoid with gradient feedback; define ACTIVATE_LEAKY_EN for a 1/64 leak outside the linear region
module activate #(
  parameter int RESW = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  activate_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FWD, ARMED, BWD} state_t;
  state_t state, next;
  logic                   arg_hs, err_hs, en_q, lin, lin_d;
  logic signed [RESW-1:0] x, e, g_out;
  logic signed [RESW+1:0] xe, t;
  logic [7:0]             act;
  assign x      = bus.arg_data;
  assign e      = bus.err_data;
  assign xe     = {{2{x[RESW-1]}}, x};
  assign t      = (xe >>> 2) + (RESW+2)'(128);
  assign act    = t[RESW+1] ? 8'h00 : (|t[RESW:8]) ? 8'hff : t[7:0];
  // Linear region -512..511 means every bit above bit 8 equals the sign
  assign lin_d  = (&x[RESW-1:9]) | ~(|x[RESW-1:9]);
`ifdef ACTIVATE_LEAKY_EN
  assign g_out  = e >>> 6;
`else
  assign g_out  = '0;
`endif
  assign bus.arg_ready = (state == IDLE) || (state == ARMED && !bus.err_valid);
  assign bus.err_ready = (state == ARMED);
  assign bus.res_valid = (state == FWD);
  assign bus.fbk_valid = (state == BWD);
  assign arg_hs = bus.arg_valid && bus.arg_ready;
  assign err_hs = bus.err_valid && bus.err_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = arg_hs ? FWD : IDLE;
      FWD:     next = bus.res_ready ? (en_q ? ARMED : IDLE) : FWD;
      ARMED:   next = err_hs ? BWD : arg_hs ? FWD : ARMED;
      default: next = bus.fbk_ready ? IDLE : BWD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.res_data <= '0;
      bus.fbk_data <= '0;
      en_q         <= 1'b0;
      lin          <= 1'b1;
    end else begin
      if (arg_hs) begin
        bus.res_data <= {{(RESW-8){1'b0}}, act};
        en_q         <= en;
        lin          <= lin_d;
      end
      if (err_hs) bus.fbk_data <= lin ? (e >>> 2) : g_out;
    end
endmodule

// File: tb/tb_activate.sv
// tb_activate: table-driven forward vectors plus directed backward, backpressure, conflict and reset sequences
module tb_activate;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  int   pass = 0, total = 0;
  activate_if #(.RESW(16)) bus ();
  activate #(.RESW(16)) dut (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [15:0] arg; logic [15:0] res; } vec_t;
  vec_t v[8];
`ifdef ACTIVATE_LEAKY_EN
  localparam logic [15:0] SAT_FBK = 16'h0004;
`else
  localparam logic [15:0] SAT_FBK = 16'h0000;
`endif
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic send_arg(input logic [15:0] a, input logic e);
    int n = 0;
    bus.arg_data = a; en = e; bus.arg_valid = 1'b1;
    #1;
    while (!bus.arg_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) check("arg_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    bus.arg_valid = 1'b0; en = $urandom_range(1);
  endtask
  task automatic send_err(input logic [15:0] d);
    int n = 0;
    bus.err_data = d; bus.err_valid = 1'b1;
    #1;
    while (!bus.err_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) check("err_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    bus.err_valid = 1'b0;
  endtask
  task automatic take_res();
    bus.res_ready = 1'b1; @(posedge clk); #1; bus.res_ready = 1'b0;
  endtask
  task automatic take_fbk();
    bus.fbk_ready = 1'b1; @(posedge clk); #1; bus.fbk_ready = 1'b0;
  endtask
  task automatic backward(input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_fbk, input string name);
    send_arg(a, 1'b1);
    @(negedge clk); check({name, "_res_valid"}, 16'(bus.res_valid), 16'd1);
    take_res();
    @(negedge clk); check({name, "_armed_err_ready"}, 16'(bus.err_ready), 16'd1);
    send_err(d);
    @(negedge clk); check({name, "_fbk_valid"}, 16'(bus.fbk_valid), 16'd1);
    check({name, "_fbk_data"}, bus.fbk_data, exp_fbk);
    take_fbk();
    @(negedge clk); check({name, "_idle"}, 16'(bus.fbk_valid | bus.err_ready), 16'd0);
  endtask
  initial begin
    logic [15:0] held;
    v[0] = '{16'h0000, 16'h0080};
    v[1] = '{16'h0100, 16'h00c0};
    v[2] = '{16'hfe00, 16'h0000};
    v[3] = '{16'h7fff, 16'h00ff};
    v[4] = '{16'h8000, 16'h0000};
    v[5] = '{16'h01ff, 16'h00ff};
    v[6] = '{16'hff00, 16'h0040};
    v[7] = '{16'hfdff, 16'h0000};
    bus.arg_valid = 0; bus.arg_data = 0; bus.res_ready = 0;
    bus.err_valid = 0; bus.err_data = 0; bus.fbk_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_res_valid", 16'(bus.res_valid), 16'd0);
    check("rst_fbk_valid", 16'(bus.fbk_valid), 16'd0);
    check("rst_arg_ready", 16'(bus.arg_ready), 16'd1);
    check("rst_err_ready", 16'(bus.err_ready), 16'd0);
    check("rst_res_data", bus.res_data, 16'h0000);
    check("rst_fbk_data", bus.fbk_data, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      send_arg(v[i].arg, 1'b0);
      @(negedge clk);
      check("fwd_res_valid", 16'(bus.res_valid), 16'd1);
      check("fwd_res_data", bus.res_data, v[i].res);
      check("fwd_err_ready", 16'(bus.err_ready), 16'd0);
      take_res();
      @(negedge clk);
      check("fwd_back_idle", 16'({bus.res_valid, bus.arg_ready, bus.err_ready}), 16'b010);
    end
    backward(16'h0040, 16'h0100, 16'h0040, "bwd_lin");
    backward(16'h0400, 16'h0100, SAT_FBK, "bwd_sat");
    backward(16'h0000, 16'hff00, 16'hffc0, "bwd_neg");
    backward(16'hfc00, 16'hf000, SAT_FBK == 0 ? 16'h0000 : 16'hffc0, "bwd_sat_neg");
    send_arg(16'h0100, 1'b0);
    @(negedge clk); held = bus.res_data;
    check("bp_first", held, 16'h00c0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_valid", 16'(bus.res_valid), 16'd1);
      check("bp_res_stable", bus.res_data, held);
      check("bp_arg_ready", 16'(bus.arg_ready), 16'd0);
    end
    take_res();
    @(negedge clk); check("bp_one_transfer", 16'(bus.res_valid), 16'd0);
    send_arg(16'h0040, 1'b1);
    take_res();
    @(negedge clk);
    bus.arg_data = 16'h0400; bus.arg_valid = 1'b1;
    bus.err_data = 16'h0100; bus.err_valid = 1'b1;
    #1; check("conf_arg_ready_low", 16'(bus.arg_ready), 16'd0);
    @(posedge clk); #1; bus.err_valid = 1'b0;
    @(negedge clk);
    check("conf_fbk_valid", 16'(bus.fbk_valid), 16'd1);
    check("conf_fbk_old_x", bus.fbk_data, 16'h0040);
    check("conf_res_valid", 16'(bus.res_valid), 16'd0);
    bus.arg_valid = 1'b0;
    take_fbk();
    send_arg(16'h0040, 1'b1);
    take_res();
    send_arg(16'h0400, 1'b1);
    @(negedge clk); check("repl_res", bus.res_data, 16'h00ff);
    take_res();
    send_err(16'h0100);
    @(negedge clk); check("repl_fbk_new_x", bus.fbk_data, SAT_FBK);
    take_fbk();
    send_arg(16'h0040, 1'b1);
    take_res();
    send_err(16'h0100);
    @(negedge clk);
    check("rst_bwd_fbk_valid_pre", 16'(bus.fbk_valid), 16'd1);
    rst_n = 1'b0;
    #1; check("rst_bwd_fbk_drop", 16'(bus.fbk_valid), 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_bwd_idle", 16'({bus.fbk_valid, bus.res_valid, bus.arg_ready, bus.err_ready}), 16'b0010);
    check("rst_bwd_fbk_data", bus.fbk_data, 16'h0000);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/activate.md
# activate

Piecewise-linear sigmoid activation stage sitting directly downstream of `associate`. It consumes each forward result `res`, produces a bounded activation in 0x0000..0x00ff, and keeps the pre-activation value. On the backward pass it accepts the error on that activation and returns the gradient-scaled error that `associate` consumes as its own `err`. Both directions use registered valid/ready handshakes. A one-entry context store ties each backward transaction to the most recent forward one.

## Interface
Parameters:
- `RESW`, 16: width of pre-activation input, activation output, error and feedback; signed Q8.8.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  training enable; sampled at the arg handshake.
- `arg_valid` / `arg_ready` / `arg_data`  in / out / in  1 / 1 / RESW  forward input: pre-activation from `associate`.
- `res_valid` / `res_ready` / `res_data`  out / in / out  1 / 1 / RESW  forward output: activation.
- `err_valid` / `err_ready` / `err_data`  in / out / in  1 / 1 / RESW  backward input: signed error on the activation.
- `fbk_valid` / `fbk_ready` / `fbk_data`  out / in / out  1 / 1 / RESW  backward output: signed error on the pre-activation.

## Operation
- States: IDLE, FWD, ARMED, BWD.
- IDLE:
  - `arg_ready`=1, `err_ready`=0.
  - On arg handshake: latch x=`arg_data` and en; compute `res_data`; go to FWD.
- FWD:
  - `res_valid`=1; `arg_ready`=0, `err_ready`=0.
  - On `res_ready`: go to ARMED if the latched en=1, else go to IDLE.
- ARMED:
  - `arg_ready`=1 and `err_ready`=1.
  - err handshake: compute `fbk_data` from the stored x; go to BWD.
  - arg handshake: overwrite x; go to FWD. The discarded context produces no feedback.
  - If both valids are high in the same cycle, err wins: `arg_ready` is forced low that cycle.
- BWD:
  - `fbk_valid`=1.
  - On `fbk_ready`: go to IDLE.
- Activation:
  - t = 128 + (x >>> 2), computed with 2 guard bits.
  - `res_data` = clamp(t, 0, 255), zero-extended.
  - Linear region is -512 <= x <= 511.
- Gradient:
  - Inside the linear region: `fbk_data` = `err_data` >>> 2 (arithmetic shift).
  - Outside the linear region: see Configuration.
  - No overflow is possible: a shift only shrinks magnitude.
- The linear-region flag is computed and stored at arg accept. Backward reuses the flag and does not recompute it.

## Timing
- Reset values:
  - state=IDLE.
  - `res_valid`=0, `fbk_valid`=0, `res_data`=0, `fbk_data`=0.
  - `arg_ready`=1, `err_ready`=0.
  - Stored x=0, stored en=0.
- Latency:
  - `res_valid` rises the cycle after the arg handshake.
  - `fbk_valid` rises the cycle after the err handshake.
- Throughput:
  - One forward transaction per 2 cycles when `res_ready` is held high.
- Output stability:
  - `res_data` and `fbk_data` are registered.
  - They stay stable while the matching valid is high and ready is low.
- Ready signals:
  - `arg_ready` and `err_ready` are combinational from state only (plus the ARMED priority rule).
  - They never depend on `res_ready` or `fbk_ready`.
- Reset mid-transaction:
  - Asserting `rst_n` low in any state immediately drops both valids.
  - The stored context is cleared; no pending feedback survives.
- Toggling `en` outside an arg handshake has no effect.

## Configuration
- `ACTIVATE_LEAKY_EN` undefined:
  - Outside the linear region, `fbk_data` = 0 (hard saturation, gradient blocked).
- `ACTIVATE_LEAKY_EN` defined:
  - Outside the linear region, `fbk_data` = `err_data` >>> 6 (leak slope 1/64).
  - Prevents dead units; the forward path is unchanged.

## Test plan
- Reset then idle:
  - Expect `res_valid`=0, `fbk_valid`=0, `arg_ready`=1, `err_ready`=0.
- Forward, en=0:
  - Args 0x0000, 0x0100, 0xfe00, 0x7fff, 0x8000 → res 0x0080, 0x00c0, 0x0000, 0x00ff, 0x0000 in turn.
  - FSM returns to IDLE each time; `err_ready` never asserts.
- Backward, en=1:
  - arg 0x0040, then err 0x0100 → fbk 0x0040.
  - arg 0x0400, then err 0x0100 → fbk 0x0000 without the macro, 0x0004 with `ACTIVATE_LEAKY_EN`.
- Backpressure:
  - Hold `res_ready`=0 for 5 cycles → `res_data` stable, `arg_ready`=0.
  - Then assert `res_ready` → exactly one transfer.
- ARMED conflicts:
  - arg and err both valid → err accepted first; fbk uses the old x.
  - A second arg while ARMED replaces the context; the next err uses the new x.
- Reset in BWD with `fbk_ready`=0:
  - `fbk_valid` drops asynchronously; state=IDLE after release.
